// File: rtl/fp_div_if.sv
// Start/done handshake and operand/result bus of the FP divider.
interface fp_div_if;
    logic        i_valid;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic        o_busy;
    logic [31:0] o_result;

    modport master (output i_valid, i_a, i_b, input o_valid, o_busy, o_result);
    modport slave  (input i_valid, i_a, i_b, output o_valid, o_busy, o_result);
endinterface

// File: rtl/fp_div.sv
// Sequential IEEE-754 single-precision divider: radix-2 restoring mantissa
// division, one quotient bit per cycle, truncating rounding, subnormals
// flushed to signed zero. Fixed latency of 26 cycles from accept to o_valid.
module fp_div #(
    parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    fp_div_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  count;
    logic        sign;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [25:0] rem;
    logic [23:0] mb;
    logic [24:0] q;
    logic        flag_nan;
    logic        flag_inf;
    logic        flag_zero;
    logic        accept;
    logic        busy;
    logic        done;
    logic        valid_q;
    logic [31:0] result_q;

    // Operand classification helpers; exponent 0 counts as zero (flush).
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    assign a_nan  = (bus.i_a[30:23] == 8'hFF) && (bus.i_a[22:0] != 23'd0);
    assign b_nan  = (bus.i_b[30:23] == 8'hFF) && (bus.i_b[22:0] != 23'd0);
    assign a_inf  = (bus.i_a[30:23] == 8'hFF) && (bus.i_a[22:0] == 23'd0);
    assign b_inf  = (bus.i_b[30:23] == 8'hFF) && (bus.i_b[22:0] == 23'd0);
    assign a_zero = (bus.i_a[30:23] == 8'h00);
    assign b_zero = (bus.i_b[30:23] == 8'h00);

    // Normalise the quotient, apply range saturation and the special cases.
    function automatic logic [31:0] pack_result(
        input logic        s,
        input logic [7:0]  ea,
        input logic [7:0]  eb,
        input logic [24:0] quo,
        input logic        is_nan,
        input logic        is_inf,
        input logic        is_zero
    );
        logic signed [9:0] e_diff;
        logic signed [9:0] e_res;
        logic [22:0]       frac;
        e_diff = signed'({2'b00, ea}) - signed'({2'b00, eb});
        if (quo[24]) begin
            frac  = quo[23:1];
            e_res = e_diff + 10'sd127;
        end else begin
            frac  = quo[22:0];
            e_res = e_diff + 10'sd126;
        end
        if (is_nan)                 pack_result = QNAN;
        else if (is_inf)            pack_result = {s, 8'hFF, 23'd0};
        else if (is_zero)           pack_result = {s, 31'd0};
        else if (e_res >= 10'sd255) pack_result = {s, 8'hFF, 23'd0};
        else if (e_res <= 10'sd0)   pack_result = {s, 31'd0};
        else                        pack_result = {s, e_res[7:0], frac};
    endfunction

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; a request arriving during CALC is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_valid) state_nxt = CALC;
            CALC:    if (count == 5'd24) state_nxt = DONE;
            DONE:    state_nxt = bus.i_valid ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded control outputs.
    always_comb begin
        busy   = (state == CALC);
        done   = (state == DONE);
        accept = bus.i_valid && (state != CALC);
    end

    // Operand capture on accept, then one restoring-division step per CALC cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count     <= 5'd0;
            sign      <= 1'b0;
            exp_a     <= 8'd0;
            exp_b     <= 8'd0;
            rem       <= 26'd0;
            mb        <= 24'd0;
            q         <= 25'd0;
            flag_nan  <= 1'b0;
            flag_inf  <= 1'b0;
            flag_zero <= 1'b0;
        end else if (accept) begin
            count     <= 5'd0;
            sign      <= bus.i_a[31] ^ bus.i_b[31];
            exp_a     <= bus.i_a[30:23];
            exp_b     <= bus.i_b[30:23];
            rem       <= {3'b001, bus.i_a[22:0]};
            mb        <= {1'b1, bus.i_b[22:0]};
            q         <= 25'd0;
            flag_nan  <= a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
            flag_inf  <= a_inf || b_zero;
            flag_zero <= a_zero || b_inf;
        end else if (busy) begin
            count <= count + 5'd1;
            if (rem >= {2'b00, mb}) begin
                rem <= (rem - {2'b00, mb}) << 1;
                q   <= {q[23:0], 1'b1};
            end else begin
                rem <= rem << 1;
                q   <= {q[23:0], 1'b0};
            end
        end
    end

    // Result register: written only from the DONE cycle, held otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q  <= 1'b0;
            result_q <= 32'd0;
        end else begin
            valid_q <= done;
            if (done)
                result_q <= pack_result(sign, exp_a, exp_b, q, flag_nan, flag_inf, flag_zero);
        end
    end

    assign bus.o_valid  = valid_q;
    assign bus.o_busy   = busy;
    assign bus.o_result = result_q;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div against a behavioural division model.
module tb_fp_div;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fp_div_if bus ();

    fp_div #(.QNAN(QNAN)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: classify, integer long division of the mantissas, then pack.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int          ea, eb, e;
        logic        s, an, bn, ai, bi, az, bz;
        logic [63:0] ma, mb, quo;
        logic [22:0] frac;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        az = (ea == 0);
        bz = (eb == 0);
        if (an || bn || (az && bz) || (ai && bi)) return QNAN;
        if (ai || bz) return {s, 8'hFF, 23'd0};
        if (az || bi) return {s, 31'd0};
        ma  = {40'd1, a[22:0]};
        mb  = {40'd1, b[22:0]};
        quo = (ma << 24) / mb;
        if (quo >= 64'd16777216) begin
            frac = quo[23:1];
            e    = ea - eb + 127;
        end else begin
            frac = quo[22:0];
            e    = ea - eb + 126;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, e[7:0], frac};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        int          cls;
        r   = $urandom;
        cls = $urandom_range(0, 11);
        case (cls)
            0:       r[30:23] = 8'h00;
            1:       begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
            2:       begin r[30:23] = 8'hFF; r[22:0] = r[22:0] | 23'd1; end
            3:       r[30:23] = 8'(($urandom_range(0, 1) != 0) ? $urandom_range(240, 254) : $urandom_range(1, 12));
            default: r[30:23] = 8'($urandom_range(100, 154));
        endcase
        return r;
    endfunction

    // Stimulus helper: present a request and step past the accepting edge.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        bus.i_valid = 1'b1;
        bus.i_a     = a;
        bus.i_b     = b;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    // Stimulus helper: edges until o_valid (counting from the accept edge), -1 on timeout.
    task automatic wait_valid(output int lat, output int busy_cycles);
        lat         = -1;
        busy_cycles = bus.o_busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.o_valid) begin
                lat = k;
                return;
            end
            if (bus.o_busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_a     = 32'd0;
        bus.i_b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.o_valid, bus.o_busy, bus.o_result} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b b=%b r=%h want 0 0 00000000",
                     bus.o_valid, bus.o_busy, bus.o_result);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va [10] = '{32'h40C00000, 32'h3F800000, 32'hC0F00000, 32'hC0000000, 32'h00000000,
                                 32'h7F800000, 32'h3F800000, 32'h7F000000, 32'h00800000, 32'h7FC12345};
        logic [31:0] vb [10] = '{32'h40000000, 32'h40400000, 32'h40200000, 32'h00000000, 32'h00000000,
                                 32'h7F800000, 32'h7F800000, 32'h00800000, 32'h40000000, 32'h3F800000};
        logic [31:0] vr [10] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'hFF800000, 32'h7FC00000,
                                 32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h00000000, 32'h7FC00000};
        int lat, bc;
        for (int i = 0; i < 10; i++) begin
            start(va[i], vb[i]);
            wait_valid(lat, bc);
            checks++;
            if (lat !== 26) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d want 26", i, lat);
            end
            checks++;
            if (bus.o_result !== vr[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: %h/%h got %h want %h", i, va[i], vb[i], bus.o_result, vr[i]);
            end
            if (i == 0) begin
                checks++;
                if (bc !== 25) begin
                    errors++;
                    $display("FAIL busy_cycles: got %0d want 25", bc);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (bus.o_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_pulse[%0d]: o_valid still %b one cycle later", i, bus.o_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, exp_r;
        int lat, bc;
        for (int i = 0; i < 40; i++) begin
            a     = rand_operand();
            b     = rand_operand();
            exp_r = ref_div(a, b);
            start(a, b);
            wait_valid(lat, bc);
            checks++;
            if (lat !== 26 || bus.o_result !== exp_r) begin
                errors++;
                $display("FAIL random[%0d]: %h/%h got %h lat %0d want %h lat 26", i, a, b, bus.o_result, lat, exp_r);
            end
        end
    endtask

    task automatic test_ignore_and_hold();
        logic [31:0] held;
        int lat, bc, extra;
        start(32'h40C00000, 32'h40000000);
        repeat (9) @(posedge clk);
        #1;
        bus.i_valid = 1'b1;
        bus.i_a     = 32'h3F800000;
        bus.i_b     = 32'h40400000;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        lat = -1;
        for (int k = 11; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.o_valid) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat !== 26 || bus.o_result !== 32'h40400000) begin
            errors++;
            $display("FAIL ignore_mid_calc: got %h lat %0d want 40400000 lat 26", bus.o_result, lat);
        end
        held  = bus.o_result;
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.o_valid || bus.o_busy || bus.o_result !== held) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL hold_idle: %0d idle cycles with activity or changed result, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        start(32'hC0F00000, 32'h40200000);
        repeat (25) @(posedge clk);
        #1;
        bus.i_valid = 1'b1;
        bus.i_a     = 32'h3F800000;
        bus.i_b     = 32'h40400000;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_result !== 32'hC0400000 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got v=%b busy=%b r=%h want 1 1 c0400000",
                     bus.o_valid, bus.o_busy, bus.o_result);
        end
        wait_valid(lat, bc);
        checks++;
        if (lat !== 26 || bus.o_result !== 32'h3EAAAAAA) begin
            errors++;
            $display("FAIL b2b_second: got %h lat %0d want 3eaaaaaa lat 26", bus.o_result, lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, spurious;
        start(32'h3F800000, 32'h40400000);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_valid, bus.o_busy, bus.o_result} !== 34'd0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b b=%b r=%h want 0 0 00000000",
                     bus.o_valid, bus.o_busy, bus.o_result);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n    = 1'b1;
        spurious = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.o_valid || bus.o_busy) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            errors++;
            $display("FAIL reset_abort: %0d cycles of activity after abort, want 0", spurious);
        end
        start(32'h40C00000, 32'h40000000);
        wait_valid(lat, bc);
        checks++;
        if (lat !== 26 || bus.o_result !== 32'h40400000) begin
            errors++;
            $display("FAIL reset_recover: got %h lat %0d want 40400000 lat 26", bus.o_result, lat);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_and_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
